switch_reader: RTL and testbench
================================

// Module: switch_reader
// PURPOSE
//  Input side of the board operator panel: samples 16 slide switches and returns debounced, validated
//  settings to the CPU/display logic. Same bit map as the LED mirror: sw[0]=run enable,
//  sw[3:1]=display select, sw[15:4]=12-bit memory address (4K words).
//  Sits between the FPGA pins and the single-cycle CPU debug/display mux. One clock domain after sync.
// PARAMETERS
//  DEBOUNCE_CYCLES  250000  clk cycles the synced vector must stay unchanged before acceptance (>=2)
//  CNT_W            18      debounce counter width; must hold DEBOUNCE_CYCLES-1
// PORTS
//  clk          in   1   system clock
//  rst_n        in   1   asynchronous active-low reset
//  sw_raw       in   16  raw switch pins, asynchronous to clk
//  run_en       out  1   debounced sw[0]
//  disp_sel     out  3   debounced sw[3:1], forced 3'b000 when invalid
//  addr         out  12  debounced sw[15:4]
//  sel_invalid  out  1   1 when debounced sw[3:1] is 3'b110 or 3'b111
//  upd          out  1   one-cycle pulse when any accepted output value changes
// BEHAVIOUR
//  - Reset (async assert, sync-released by caller): sync regs, candidate, stable vector = 0;
//    counter = 0; all outputs 0 (run_en=0, disp_sel=0, addr=0, sel_invalid=0, upd=0).
//  - Sync: 2-flop synchronizer on all 16 bits -> s2. No logic on first flop.
//  - Debounce FSM on whole vector, states IDLE / COUNT:
//    IDLE: s2 == stable -> stay, counter=0. s2 != stable -> cand<=s2, counter<=0, go COUNT.
//    COUNT: s2 != cand -> cand<=s2, counter<=0 (restart, stay COUNT).
//           s2 == cand && counter == DEBOUNCE_CYCLES-1 -> stable<=cand, upd<=1 next cycle, go IDLE.
//           s2 == cand && s2 == stable (bounced back) -> go IDLE, no upd.
//           else counter++.
//  - Latency: pin change to output = 2 sync cycles + DEBOUNCE_CYCLES + 1 register cycle.
//  - Outputs are registered, decoded from stable: disp_sel = sel_invalid ? 0 : stable[3:1].
//  - upd high exactly one cycle per acceptance; never two consecutive cycles.
//  - Counter never wraps: saturates at compare point; no overflow with CNT_W sized correctly.
//  - Reset mid-COUNT: return to IDLE with stable=0; any bounce in progress discarded.
// CONFIGURATION
//  SW_READER_ADDR_LATCH_EN defined: adds port `load_btn in 1` (raw push-button). load_btn is
//    synced and debounced with the same DEBOUNCE_CYCLES; addr updates only on the debounced
//    rising edge of load_btn (takes stable[15:4] at that time). run_en/disp_sel still track live.
//    upd pulses on addr load and on run_en/disp_sel change; not on unloaded sw[15:4] moves.
//  Not defined: no load_btn port; addr tracks stable[15:4] as above.
// TESTING  (DEBOUNCE_CYCLES=8 for simulation)
//  1. Reset: rst_n=0 with sw_raw=16'hFFFF -> all outputs 0; release, hold -> after 2+8+1 cycles
//     run_en=1, sel_invalid=1, disp_sel=0, addr=12'hFFF, one upd pulse.
//  2. Clean change sw_raw 16'h0000 -> 16'h1233 held -> run_en=1, disp_sel=3'b001, addr=12'h123,
//     upd one cycle at cycle 11 after change.
//  3. Bounce: toggle sw[0] every 3 cycles for 30 cycles then hold 1 -> no upd during toggling;
//     exactly one upd 11 cycles after last edge.
//  4. Glitch shorter than window: sw_raw 0 -> 16'h000A for 5 cycles -> back 0 -> no upd, outputs 0.
//  5. Async reset mid-COUNT (cycle 4 of count) -> outputs 0 immediately, no upd after release
//     unless input differs from 0.
//  6. With SW_READER_ADDR_LATCH_EN: set sw[15:4]=12'hABC, no button -> addr stays 0, no upd;
//     press load_btn held >8 cycles -> addr=12'hABC, single upd.

Source files
------------

// File: rtl/switch_reader.sv
// Operator-panel switch front end: 2-flop sync, whole-vector debounce, registered decode.
// Optional SW_READER_ADDR_LATCH_EN: addr only loads on a debounced load_btn rising edge.
module switch_reader #(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int CNT_W           = 18
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] sw_raw,
`ifdef SW_READER_ADDR_LATCH_EN
    input  logic        load_btn,
`endif
    output logic        run_en,
    output logic [2:0]  disp_sel,
    output logic [11:0] addr,
    output logic        sel_invalid,
    output logic        upd
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_COUNT = 1'b1
    } state_t;

    logic [15:0]      s1_q, s2_q;
    logic [15:0]      cand_q, cand_d;
    logic [15:0]      stable_q, stable_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    state_t           state_q, state_d;

    logic             run_q, run_d;
    logic [2:0]       disp_q, disp_d;
    logic [11:0]      addr_q, addr_d;
    logic             inv_q, inv_d;
    logic             upd_q, upd_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q <= '0;
            s2_q <= '0;
        end else begin
            s1_q <= sw_raw;
            s2_q <= s1_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            cand_q   <= '0;
            stable_q <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            cand_q   <= cand_d;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
        end
    end

    // A candidate is accepted only after it has been seen unchanged for the full window;
    // returning to the already-stable value abandons the attempt silently.
    always_comb begin
        state_d  = state_q;
        cand_d   = cand_q;
        stable_d = stable_q;
        cnt_d    = cnt_q;
        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (s2_q != stable_q) begin
                    cand_d  = s2_q;
                    state_d = ST_COUNT;
                end
            end
            ST_COUNT: begin
                if (s2_q != cand_q) begin
                    cand_d = s2_q;
                    cnt_d  = '0;
                end else if (s2_q == stable_q) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    stable_d = cand_q;
                    state_d  = ST_IDLE;
                    cnt_d    = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

`ifdef SW_READER_ADDR_LATCH_EN
    logic             b1_q, b2_q;
    logic             btn_stable_q, btn_stable_d;
    logic             btn_pend_q, btn_pend_d;
    logic [CNT_W-1:0] btn_cnt_q, btn_cnt_d;
    logic             load_rise;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            b1_q         <= 1'b0;
            b2_q         <= 1'b0;
            btn_stable_q <= 1'b0;
            btn_pend_q   <= 1'b0;
            btn_cnt_q    <= '0;
        end else begin
            b1_q         <= load_btn;
            b2_q         <= b1_q;
            btn_stable_q <= btn_stable_d;
            btn_pend_q   <= btn_pend_d;
            btn_cnt_q    <= btn_cnt_d;
        end
    end

    // Single-bit copy of the vector debouncer, so the button has the same acceptance timing.
    always_comb begin
        btn_stable_d = btn_stable_q;
        btn_pend_d   = btn_pend_q;
        btn_cnt_d    = btn_cnt_q;
        load_rise    = 1'b0;
        if (!btn_pend_q) begin
            btn_cnt_d = '0;
            if (b2_q != btn_stable_q) begin
                btn_pend_d = 1'b1;
            end
        end else if (b2_q == btn_stable_q) begin
            btn_pend_d = 1'b0;
            btn_cnt_d  = '0;
        end else if (btn_cnt_q == CNT_LAST) begin
            btn_stable_d = b2_q;
            btn_pend_d   = 1'b0;
            btn_cnt_d    = '0;
            load_rise    = b2_q;
        end else begin
            btn_cnt_d = btn_cnt_q + 1'b1;
        end
    end
`endif

    always_comb begin
        inv_d  = stable_d[3] & stable_d[2];
        run_d  = stable_d[0];
        disp_d = inv_d ? 3'b000 : stable_d[3:1];
`ifdef SW_READER_ADDR_LATCH_EN
        addr_d = load_rise ? stable_d[15:4] : addr_q;
`else
        addr_d = stable_d[15:4];
`endif
        upd_d  = ({run_d, disp_d, addr_d, inv_d} != {run_q, disp_q, addr_q, inv_q});
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_q  <= 1'b0;
            disp_q <= 3'b000;
            addr_q <= '0;
            inv_q  <= 1'b0;
            upd_q  <= 1'b0;
        end else begin
            run_q  <= run_d;
            disp_q <= disp_d;
            addr_q <= addr_d;
            inv_q  <= inv_d;
            upd_q  <= upd_d;
        end
    end

    assign run_en      = run_q;
    assign disp_sel    = disp_q;
    assign addr        = addr_q;
    assign sel_invalid = inv_q;
    assign upd         = upd_q;

endmodule

// File: tb/tb_switch_reader.sv
// Directed bench for switch_reader with an 8-cycle debounce window.
module tb_switch_reader;

    logic        clk;
    logic        rst_n;
    logic [15:0] sw_raw;
    logic        load_btn;
    logic        run_en;
    logic [2:0]  disp_sel;
    logic [11:0] addr;
    logic        sel_invalid;
    logic        upd;

    int n_vec = 0;
    int n_err = 0;

`ifdef SW_READER_ADDR_LATCH_EN
    localparam bit LATCH = 1'b1;
`else
    localparam bit LATCH = 1'b0;
`endif

    switch_reader #(
        .DEBOUNCE_CYCLES(8),
        .CNT_W          (4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .sw_raw     (sw_raw),
`ifdef SW_READER_ADDR_LATCH_EN
        .load_btn   (load_btn),
`endif
        .run_en     (run_en),
        .disp_sel   (disp_sel),
        .addr       (addr),
        .sel_invalid(sel_invalid),
        .upd        (upd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end else begin
            $display("ok   %s: %h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Runs n cycles, counting upd pulses and noting the cycle of the first one.
    task automatic watch(input int n, output int pulses, output int first);
        pulses = 0;
        first  = 0;
        for (int i = 0; i < n; i++) begin
            tick();
            if (upd === 1'b1) begin
                pulses++;
                if (first == 0) first = i + 1;
            end
        end
    endtask

    function automatic logic [31:0] outs();
        return {15'd0, run_en, sel_invalid, disp_sel, addr};
    endfunction

    function automatic logic [31:0] exp_outs(input logic r, input logic inv,
                                             input logic [2:0] d, input logic [11:0] a);
        return {15'd0, r, inv, d, (LATCH ? 12'h000 : a)};
    endfunction

    initial begin
        int p, f, p1, p2, tot;
        logic [15:0] v;

        // 1: reset with all switches up
        rst_n    = 1'b0;
        sw_raw   = 16'hFFFF;
        load_btn = 1'b0;
        repeat (3) tick();
        check("t1_reset_outs", outs(), 32'h0);
        check("t1_reset_upd", {31'd0, upd}, 32'h0);
        rst_n = 1'b1;
        watch(20, p, f);
        check("t1_upd_count", p, 1);
        check("t1_upd_cycle", f, 11);
        check("t1_outs", outs(), exp_outs(1'b1, 1'b1, 3'b000, 12'hFFF));

        // 2: clean change
        sw_raw = 16'h0000;
        watch(20, p, f);
        check("t2_settle_upd", p, 1);
        sw_raw = 16'h1233;
        watch(20, p, f);
        check("t2_upd_count", p, 1);
        check("t2_upd_cycle", f, 11);
        check("t2_outs", outs(), exp_outs(1'b1, 1'b0, 3'b001, 12'h123));

        // 3: sw[0] bouncing every 3 cycles, then held high
        sw_raw = 16'h1232;
        watch(20, p, f);
        check("t3_settle_upd", p, 1);
        tot = 0;
        v = 16'h1232;
        for (int k = 0; k < 10; k++) begin
            v[0]   = ~v[0];
            sw_raw = v;
            watch(3, p, f);
            tot += p;
        end
        check("t3_bounce_upd", tot, 0);
        check("t3_bounce_run", {31'd0, run_en}, 32'h0);
        sw_raw = 16'h1233;
        watch(20, p, f);
        check("t3_upd_count", p, 1);
        check("t3_upd_cycle", f, 11);
        check("t3_run", {31'd0, run_en}, 32'h1);

        // 4: glitch shorter than the window
        sw_raw = 16'h0000;
        watch(20, p, f);
        check("t4_settle_upd", p, 1);
        sw_raw = 16'h000A;
        watch(5, p1, f);
        sw_raw = 16'h0000;
        watch(20, p2, f);
        check("t4_glitch_upd", p1 + p2, 0);
        check("t4_outs", outs(), 32'h0);

        // 5: async reset while counting
        sw_raw = 16'h0012;
        watch(20, p, f);
        check("t5_settle_upd", p, 1);
        check("t5_settle_disp", {29'd0, disp_sel}, 32'h1);
        sw_raw = 16'h0013;
        repeat (6) tick();
        rst_n = 1'b0;
        #1;
        check("t5_async_outs", outs(), 32'h0);
        sw_raw = 16'h0000;
        repeat (2) tick();
        rst_n = 1'b1;
        watch(20, p, f);
        check("t5_after_upd", p, 0);
        check("t5_after_outs", outs(), 32'h0);

`ifdef SW_READER_ADDR_LATCH_EN
        // 6: address only loads on the debounced button press
        sw_raw = 16'hABC0;
        watch(20, p, f);
        check("t6_noload_upd", p, 0);
        check("t6_noload_addr", {20'd0, addr}, 32'h0);
        load_btn = 1'b1;
        watch(20, p, f);
        check("t6_load_upd", p, 1);
        check("t6_load_cycle", f, 11);
        check("t6_load_addr", {20'd0, addr}, 32'hABC);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
